cordic_ctrl: RTL

Command-side controller that drives the iterative `cordic` core. It accepts operand requests on a valid/ready command port and applies circular-mode quadrant pre-correction. It then launches the core with a one-cycle enable, holds the core operands stable until the core's `valid` pulse, and returns results on a valid/ready response port with tag and error status. It sits between the datapath scheduler and one `cordic` instance, with the core's own inputs and outputs wired straight to the `core_*` ports.

---
 rtl/cordic_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cordic_ctrl.sv
// rtl/cordic_ctrl.sv - command/response controller for the iterative cordic core
// Circular-mode quadrant pre-correction is built only when CORDIC_QUAD_CORR_EN is defined.
module cordic_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [1:0]       cmd_coord,
    input  logic [WIDTH-1:0] cmd_x,
    input  logic [WIDTH-1:0] cmd_y,
    input  logic [WIDTH-1:0] cmd_z,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             core_enable,
    output logic [1:0]       core_mode_op,
    output logic [1:0]       core_mode_coord,
    output logic [WIDTH-1:0] core_x,
    output logic [WIDTH-1:0] core_y,
    output logic [WIDTH-1:0] core_z,
    output logic             core_rst_o,
    input  logic [WIDTH-1:0] core_x_out,
    input  logic [WIDTH-1:0] core_y_out,
    input  logic [WIDTH-1:0] core_z_out,
    input  logic             core_valid,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_x,
    output logic [WIDTH-1:0] rsp_y,
    output logic [WIDTH-1:0] rsp_z,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               illegal;
    logic               timeout;
    logic [WIDTH-1:0]   x_c, y_c, z_c;

    assign illegal = (cmd_coord == 2'b10);

`ifdef CORDIC_QUAD_CORR_EN
    localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};

    function automatic logic [WIDTH-1:0] sat_neg(input logic [WIDTH-1:0] v);
        return (v == S_MIN) ? S_MAX : (~v + WIDTH'(1));
    endfunction

    logic flip;

    // Fold the operand into the core's convergence range by a half-turn rotation.
    always_comb begin
        flip = 1'b0;
        if (cmd_coord == 2'b01) begin
            if (cmd_op == 2'b00)
                flip = cmd_z[WIDTH-1] ^ cmd_z[WIDTH-2];
            else if (cmd_op == 2'b01)
                flip = cmd_x[WIDTH-1];
        end
        x_c = flip ? sat_neg(cmd_x) : cmd_x;
        y_c = flip ? sat_neg(cmd_y) : cmd_y;
        z_c = flip ? {~cmd_z[WIDTH-1], cmd_z[WIDTH-2:0]} : cmd_z;
    end
`else
    assign x_c = cmd_x;
    assign y_c = cmd_y;
    assign z_c = cmd_z;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        cmd_ready   = 1'b0;
        core_enable = 1'b0;
        rsp_valid   = 1'b0;
        timeout     = 1'b0;
        core_rst_o  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid)
                    state_nxt = illegal ? RESP : ISSUE;
            end
            ISSUE: begin
                core_enable = 1'b1;
                state_nxt   = WAIT;
            end
            WAIT: begin
                // A result arriving on the last allowed cycle still counts.
                timeout    = (cnt == CNT_W'(TIMEOUT - 1)) && !core_valid;
                core_rst_o = timeout;
                if (core_valid || timeout)
                    state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt             <= '0;
            core_mode_op    <= '0;
            core_mode_coord <= '0;
            core_x          <= '0;
            core_y          <= '0;
            core_z          <= '0;
            rsp_x           <= '0;
            rsp_y           <= '0;
            rsp_z           <= '0;
            rsp_tag         <= '0;
            rsp_err         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        rsp_tag <= cmd_tag;
                        rsp_x   <= '0;
                        rsp_y   <= '0;
                        rsp_z   <= '0;
                        rsp_err <= illegal;
                        if (!illegal) begin
                            core_mode_op    <= cmd_op;
                            core_mode_coord <= cmd_coord;
                            core_x          <= x_c;
                            core_y          <= y_c;
                            core_z          <= z_c;
                        end
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (core_valid) begin
                        rsp_x   <= core_x_out;
                        rsp_y   <= core_y_out;
                        rsp_z   <= core_z_out;
                        rsp_err <= 1'b0;
                    end else if (timeout) begin
                        rsp_x   <= '0;
                        rsp_y   <= '0;
                        rsp_z   <= '0;
                        rsp_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
